// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
//
// Shares the single read port of the boot/instruction ROM between the CPU
// instruction-fetch path and the data-load path. Each request is range- and
// alignment-checked against the ROM window. A bad request is answered with an
// error and never reaches the ROM. A good one drives rom_addr/rom_read and
// waits ROM_LATENCY extra cycles before the read data is captured. Only one
// transaction is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; drops any in-flight access, no ack
//   if_req     fetch request, held until if_ack
//   if_addr    fetch byte address, stable while if_req is high
//   if_ack     one-cycle response strobe for the fetch path
//   if_rdata   fetched word, valid with if_ack, held until the next fetch ack
//   if_err     fetch was out of range or misaligned, valid with if_ack
//   d_req / d_addr / d_ack / d_rdata / d_err
//              the same protocol for data loads
//   rom_addr   registered byte address presented to the ROM
//   rom_read   high while a ROM access is in progress
//   rom_rdata  little-endian word returned by the ROM
//   busy       high whenever the arbiter is not idle
module rom_access_arbiter #(
    parameter logic [31:0] ROM_BASE    = 32'hBFC00000,
    parameter int          ROM_BYTES   = 3000,
    parameter int          ROM_LATENCY = 0,
    parameter int          MAX_STREAK  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] rom_addr,
    output logic        rom_read,
    input  logic [31:0] rom_rdata,
    output logic        busy
);

    // Largest offset at which a whole 32-bit word still fits in the window.
    localparam logic [31:0] LAST_OFF = 32'(ROM_BYTES - 4);
    localparam int          SW       = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          winner_d;   // 1: data path owns the current transaction
    logic [31:0]   cnt;        // remaining wait cycles in ACCESS
    logic [SW-1:0] streak;     // data grants since the last fetch grant

    logic          grant_f;
    logic          grant_d;
    logic [31:0]   req_addr;
    logic          req_ok;

    // The offset subtraction wraps, so addresses below ROM_BASE turn into
    // huge offsets and fail the upper-bound test along with past-end ones.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - ROM_BASE;
        return (a[1:0] == 2'b00) && (off <= LAST_OFF);
    endfunction

    always_comb begin
        state_nx = state;
        grant_f  = 1'b0;
        grant_d  = 1'b0;
        req_addr = if_addr;
        req_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data normally wins; a fetch starved for MAX_STREAK
                    // data grants gets the next slot.
                    if (if_req && (!d_req || streak == STREAK_MAX)) begin
                        grant_f = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                    req_addr = grant_f ? if_addr : d_addr;
                    req_ok   = addr_ok(req_addr);
                    state_nx = req_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (cnt == 32'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            winner_d <= 1'b0;
            cnt      <= 32'd0;
            streak   <= '0;
            rom_addr <= 32'd0;
            rom_read <= 1'b0;
            if_rdata <= 32'd0;
            if_err   <= 1'b0;
            d_rdata  <= 32'd0;
            d_err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        winner_d <= grant_d;
                        // Only data grants that actually make a fetch wait
                        // count towards the starvation limit.
                        if (grant_f) begin
                            streak <= '0;
                        end else if (if_req) begin
                            streak <= streak + SW'(1);
                        end
                        if (req_ok) begin
                            rom_addr <= req_addr;
                            rom_read <= 1'b1;
                            cnt      <= 32'(ROM_LATENCY);
                        end else if (grant_f) begin
                            if_rdata <= 32'd0;
                            if_err   <= 1'b1;
                        end else begin
                            d_rdata  <= 32'd0;
                            d_err    <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        rom_read <= 1'b0;
                        if (winner_d) begin
                            d_rdata <= rom_rdata;
                            d_err   <= 1'b0;
                        end else begin
                            if_rdata <= rom_rdata;
                            if_err   <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_ack = (state == RESP) && !winner_d;
    assign d_ack  = (state == RESP) && winner_d;
    assign busy   = (state != IDLE);

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Sequences and shares the single read port of the boot/instruction ROM (reset window at 0xBFC00000) between the CPU instruction-fetch path and the data-load path. Range- and alignment-checks every request, returns an error without touching the ROM, and counts a configurable ROM read latency. At most one transaction is in flight. Sits between the CPU core and ROM_module.

## Interface
- ROM_BASE, 32'hBFC00000, byte address of the first ROM byte
- ROM_BYTES, 3000, ROM window size in bytes
- ROM_LATENCY, 0, cycles after rom_addr is presented before rom_rdata is valid (0 = combinational ROM)
- MAX_STREAK, 4, consecutive data grants allowed while a fetch is pending

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address, stable while if_req is high
- if_ack  out  1  one-cycle response strobe
- if_rdata  out  32  fetched word, valid with if_ack
- if_err  out  1  request was out of range or misaligned, valid with if_ack
- d_req / d_addr / d_ack / d_rdata / d_err  in/in/out/out/out  1/32/1/32/1  same protocol for data loads
- rom_addr  out  32  address to the ROM
- rom_read  out  1  high while a ROM access is in progress
- rom_rdata  in  32  little-endian word assembled by the ROM
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: with no request, stay in IDLE. With a request, arbitrate, latch the winner and its address, and compute validity:
  - offset = addr − ROM_BASE (32-bit unsigned, wraps).
  - valid iff addr[1:0]==0 and offset ≤ ROM_BYTES−4.
  - Valid: register rom_addr=addr, rom_read=1, latency counter=ROM_LATENCY, go to ACCESS.
  - Invalid: rdata=0, err=1, go to RESP. No ROM access is made.
- ACCESS: if the counter is nonzero, decrement it. If it is 0, capture rom_rdata into the winner's rdata, set err=0, clear rom_read, go to RESP.
- RESP: assert the winner's ack for exactly one cycle, then go to IDLE. Requests are not sampled in RESP.
- Arbitration:
  - Data beats fetch, except when streak==MAX_STREAK; then fetch wins.
  - streak increments on each data grant while if_req is high, and resets to 0 on any fetch grant.
  - A single requester always wins.
- The loser's req stays pending and is served on a later IDLE. Requesters must keep addr stable until ack, and deassert req or present a new address in the cycle after ack.
- rdata and err hold their last values between acks. Only ack is qualified.
- reset: all state returns to IDLE immediately. An in-flight access is discarded with no ack. streak=0.

## Timing
- Reset values: if_ack=d_ack=0, if_rdata=d_rdata=0, if_err=d_err=0, rom_addr=0, rom_read=0, busy=0.
- A valid request first seen in IDLE at cycle T:
  - rom_addr is presented from T+1.
  - rom_rdata is sampled at the end of cycle T+1+ROM_LATENCY.
  - ack is asserted in cycle T+2+ROM_LATENCY.
- An invalid request seen at T: ack with err=1 in cycle T+1.
- The next request can be accepted at T+3+ROM_LATENCY (valid) or T+2 (invalid). Peak throughput is one word per 3+ROM_LATENCY cycles.
- Simultaneous if_req and d_req in IDLE: exactly one grant, per the arbitration rule.
- A req that rises in ACCESS or RESP waits for IDLE.

## Test plan
- Reset, then ROM word at 0xBFC00000 = 0x2408_0005, ROM_LATENCY=0. if_req with if_addr=0xBFC00000 → if_ack 2 cycles later, if_rdata=0x24080005, if_err=0.
- ROM_LATENCY=3, d_req with d_addr=0xBFC00004 → d_ack exactly 5 cycles after first sample, rom_read high for 4 cycles, correct word returned.
- Error paths, with rom_read staying 0 in every case, each giving ack after 1 cycle with err=1 and rdata=0:
  - if_addr=0xBFC00002 (misaligned).
  - if_addr=0xBFBFFFFC (below base).
  - if_addr=ROM_BASE+ROM_BYTES (past end).
- if_req and d_req held continuously, MAX_STREAK=4, distinct addresses → grant order D,D,D,D,F,D,D,D,D,F; no ack is lost or duplicated.
- Assert reset during ACCESS with ROM_LATENCY=5 → no ack issued, all outputs 0 next cycle. After release, a pending if_req is served normally.
- Back-to-back fetches at 0xBFC00000, then 0xBFC00004 with ROM_LATENCY=0 → acks 3 cycles apart, each with the correct data.
